id_ex_stage: RTL and testbench

- ID/EX pipeline register for the 5-stage core. Sits directly downstream of the register file and decoder.
- Captures the register-file read data (RS1/RS2, already write-through bypassed) together with the decoded fields, and presents them to EX.
- Detects load-use hazards and inserts a one-cycle bubble. Honours EX back-pressure and branch flush.
- Keeps saturating bubble and stall counters for performance debug.

---
 rtl/id_ex_stage.sv | 100 ++++++++++
 tb/tb_id_ex_stage.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded fields and register-file read
// data, inserts a one-cycle bubble on load-use hazards, honours EX
// back-pressure and branch flush, and keeps saturating bubble/stall counters.
module id_ex_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned CW    = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             id_valid_i,
  output logic             id_ready_o,
  input  logic [XLEN-1:0]  id_pc_i,
  input  logic [XLEN-1:0]  id_imm_i,
  input  logic [AW-1:0]    id_rs1addr_i,
  input  logic [AW-1:0]    id_rs2addr_i,
  input  logic [AW-1:0]    id_rdaddr_i,
  input  logic [XLEN-1:0]  id_rs1data_i,
  input  logic [XLEN-1:0]  id_rs2data_i,
  input  logic             id_uses_rs1_i,
  input  logic             id_uses_rs2_i,
  input  logic [CW-1:0]    id_ctrl_i,
  input  logic             ex_ready_i,
  input  logic             flush_i,
  output logic             ex_valid_o,
  output logic [XLEN-1:0]  ex_pc_o,
  output logic [XLEN-1:0]  ex_imm_o,
  output logic [XLEN-1:0]  ex_rs1data_o,
  output logic [XLEN-1:0]  ex_rs2data_o,
  output logic [AW-1:0]    ex_rs1addr_o,
  output logic [AW-1:0]    ex_rs2addr_o,
  output logic [AW-1:0]    ex_rdaddr_o,
  output logic [CW-1:0]    ex_ctrl_o,
  output logic [CNT_W-1:0] lu_bubble_cnt_o,
  output logic [CNT_W-1:0] ex_stall_cnt_o
);

  localparam int unsigned     MEMREAD_BIT = 1;
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  logic hz_c;
  logic rs1_match_c;
  logic rs2_match_c;

  // Load-use hazard: EX holds a load to a non-zero rd that ID wants to read.
  always_comb begin
    rs1_match_c = id_uses_rs1_i && (id_rs1addr_i == ex_rdaddr_o);
    rs2_match_c = id_uses_rs2_i && (id_rs2addr_i == ex_rdaddr_o);
    hz_c        = ex_valid_o && ex_ctrl_o[MEMREAD_BIT] && (ex_rdaddr_o != '0)
                  && id_valid_i && (rs1_match_c || rs2_match_c);
  end

  // Consume ID on flush (instruction is killed) or when EX advances without hazard.
  assign id_ready_o = rst_n_i && (flush_i || (ex_ready_i && !hz_c));

  // Pipeline register and performance counters, flush > stall > bubble > capture.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ex_valid_o      <= 1'b0;
      ex_pc_o         <= '0;
      ex_imm_o        <= '0;
      ex_rs1data_o    <= '0;
      ex_rs2data_o    <= '0;
      ex_rs1addr_o    <= '0;
      ex_rs2addr_o    <= '0;
      ex_rdaddr_o     <= '0;
      ex_ctrl_o       <= '0;
      lu_bubble_cnt_o <= '0;
      ex_stall_cnt_o  <= '0;
    end else if (flush_i) begin
      ex_valid_o <= 1'b0;
      ex_ctrl_o  <= '0;
    end else if (!ex_ready_i) begin
      if (ex_valid_o && (ex_stall_cnt_o != CNT_MAX)) begin
        ex_stall_cnt_o <= ex_stall_cnt_o + CNT_W'(1);
      end
    end else if (hz_c) begin
      ex_valid_o <= 1'b0;
      ex_ctrl_o  <= '0;
      if (lu_bubble_cnt_o != CNT_MAX) begin
        lu_bubble_cnt_o <= lu_bubble_cnt_o + CNT_W'(1);
      end
    end else if (id_valid_i) begin
      ex_valid_o   <= 1'b1;
      ex_pc_o      <= id_pc_i;
      ex_imm_o     <= id_imm_i;
      ex_rs1data_o <= id_rs1data_i;
      ex_rs2data_o <= id_rs2data_i;
      ex_rs1addr_o <= id_rs1addr_i;
      ex_rs2addr_o <= id_rs2addr_i;
      ex_rdaddr_o  <= id_rdaddr_i;
      ex_ctrl_o    <= id_ctrl_i;
    end else begin
      ex_valid_o <= 1'b0;
      ex_ctrl_o  <= '0;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: driver pushes predicted responses,
// independent monitors pop and compare against the DUT.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n_i;
  logic        id_valid_i, id_ready_o;
  logic [31:0] id_pc_i, id_imm_i, id_rs1data_i, id_rs2data_i;
  logic [4:0]  id_rs1addr_i, id_rs2addr_i, id_rdaddr_i;
  logic        id_uses_rs1_i, id_uses_rs2_i;
  logic [7:0]  id_ctrl_i;
  logic        ex_ready_i, flush_i, ex_valid_o;
  logic [31:0] ex_pc_o, ex_imm_o, ex_rs1data_o, ex_rs2data_o;
  logic [4:0]  ex_rs1addr_o, ex_rs2addr_o, ex_rdaddr_o;
  logic [7:0]  ex_ctrl_o;
  logic [15:0] lu_bubble_cnt_o, ex_stall_cnt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk_i(clk), .rst_n_i(rst_n_i),
    .id_valid_i(id_valid_i), .id_ready_o(id_ready_o),
    .id_pc_i(id_pc_i), .id_imm_i(id_imm_i),
    .id_rs1addr_i(id_rs1addr_i), .id_rs2addr_i(id_rs2addr_i), .id_rdaddr_i(id_rdaddr_i),
    .id_rs1data_i(id_rs1data_i), .id_rs2data_i(id_rs2data_i),
    .id_uses_rs1_i(id_uses_rs1_i), .id_uses_rs2_i(id_uses_rs2_i),
    .id_ctrl_i(id_ctrl_i), .ex_ready_i(ex_ready_i), .flush_i(flush_i),
    .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o), .ex_imm_o(ex_imm_o),
    .ex_rs1data_o(ex_rs1data_o), .ex_rs2data_o(ex_rs2data_o),
    .ex_rs1addr_o(ex_rs1addr_o), .ex_rs2addr_o(ex_rs2addr_o), .ex_rdaddr_o(ex_rdaddr_o),
    .ex_ctrl_o(ex_ctrl_o), .lu_bubble_cnt_o(lu_bubble_cnt_o), .ex_stall_cnt_o(ex_stall_cnt_o)
  );

  typedef struct {
    bit        rst_n, id_valid, uses1, uses2, ex_ready, flush;
    bit [31:0] pc, imm, d1, d2;
    bit [4:0]  a1, a2, rd;
    bit [7:0]  ctrl;
  } stim_t;

  typedef struct {
    bit          valid;
    bit [31:0]   pc, imm, d1, d2;
    bit [4:0]    a1, a2, rd;
    bit [7:0]    ctrl;
    int unsigned bub, stall;
  } ex_t;

  ex_t m;
  ex_t exp_q[$];
  bit  rdy_q[$];

  localparam int unsigned SAT = 65535;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus and predict the DUT's response from the rules.
  task automatic step(input stim_t s, output bit rdy);
    bit load_in_ex, hz;
    @(negedge clk);
    rst_n_i = s.rst_n;  id_valid_i = s.id_valid; id_pc_i = s.pc; id_imm_i = s.imm;
    id_rs1addr_i = s.a1; id_rs2addr_i = s.a2; id_rdaddr_i = s.rd;
    id_rs1data_i = s.d1; id_rs2data_i = s.d2; id_uses_rs1_i = s.uses1;
    id_uses_rs2_i = s.uses2; id_ctrl_i = s.ctrl; ex_ready_i = s.ex_ready; flush_i = s.flush;
    load_in_ex = m.valid && m.ctrl[1] && (m.rd != 0);
    hz  = load_in_ex && s.id_valid && ((s.uses1 && s.a1 == m.rd) || (s.uses2 && s.a2 == m.rd));
    rdy = s.rst_n && (s.flush || (s.ex_ready && !hz));
    rdy_q.push_back(rdy);
    if (!s.rst_n) m = '{default: 0};
    else if (s.flush) begin m.valid = 0; m.ctrl = 0; end
    else if (!s.ex_ready) begin if (m.valid && m.stall < SAT) m.stall++; end
    else if (hz) begin m.valid = 0; m.ctrl = 0; if (m.bub < SAT) m.bub++; end
    else if (s.id_valid) begin
      m.valid = 1; m.pc = s.pc; m.imm = s.imm; m.d1 = s.d1; m.d2 = s.d2;
      m.a1 = s.a1; m.a2 = s.a2; m.rd = s.rd; m.ctrl = s.ctrl;
    end else begin m.valid = 0; m.ctrl = 0; end
    exp_q.push_back(m);
  endtask

  function automatic stim_t instr(input bit [31:0] pc, input bit [4:0] rd, input bit [4:0] a1,
                                  input bit [4:0] a2, input bit u1, input bit u2, input bit [7:0] ctrl);
    stim_t s;
    s = '{default: 0};
    s.rst_n = 1; s.ex_ready = 1; s.id_valid = 1; s.pc = pc; s.rd = rd; s.a1 = a1; s.a2 = a2;
    s.uses1 = u1; s.uses2 = u2; s.ctrl = ctrl; s.imm = pc ^ 32'h5a5a_0000;
    s.d1 = $urandom; s.d2 = $urandom;
    return s;
  endfunction

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  // Monitor: registered outputs after each active edge.
  initial forever begin
    ex_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("ex_valid", ex_valid_o, e.valid);
      chk("ex_ctrl", ex_ctrl_o, e.ctrl);
      chk("bubble_cnt", lu_bubble_cnt_o, e.bub);
      chk("stall_cnt", ex_stall_cnt_o, e.stall);
      if (e.valid) begin
        chk("ex_pc", ex_pc_o, e.pc);
        chk("ex_imm", ex_imm_o, e.imm);
        chk("ex_rs1data", ex_rs1data_o, e.d1);
        chk("ex_rs2data", ex_rs2data_o, e.d2);
        chk("ex_addrs", {ex_rs1addr_o, ex_rs2addr_o, ex_rdaddr_o}, {e.a1, e.a2, e.rd});
      end
    end
  end

  // Monitor: combinational ready once the cycle's inputs have settled.
  initial forever begin
    bit r;
    @(negedge clk);
    #2;
    if (rdy_q.size() != 0) begin
      r = rdy_q.pop_front();
      chk("id_ready", id_ready_o, r);
    end
  end

  localparam bit [7:0] C_ALU  = 8'h41;
  localparam bit [7:0] C_LOAD = 8'h1B;

  initial begin
    stim_t s, rs, cur;
    bit    rdy, pending;
    m = '{default: 0};
    rst_n_i = 0; id_valid_i = 0; id_pc_i = 0; id_imm_i = 0; id_rs1addr_i = 0;
    id_rs2addr_i = 0; id_rdaddr_i = 0; id_rs1data_i = 0; id_rs2data_i = 0;
    id_uses_rs1_i = 0; id_uses_rs2_i = 0; id_ctrl_i = 0; ex_ready_i = 1; flush_i = 0;

    rs = instr(32'h0, 5'd1, 5'd2, 5'd3, 1, 1, C_ALU);
    rs.rst_n = 0;
    step(rs, rdy);
    step(rs, rdy);
    #1 chk("reset_valid", ex_valid_o, 0);
    chk("reset_ready", id_ready_o, 0);

    // Back-to-back ALU ops.
    step(instr(32'h100, 5'd3, 5'd1, 5'd2, 1, 1, C_ALU), rdy);
    after_edge();
    chk("add_pc", ex_pc_o, 32'h100);
    chk("add_valid", ex_valid_o, 1);
    step(instr(32'h104, 5'd4, 5'd3, 5'd1, 1, 1, C_ALU), rdy);
    after_edge();
    chk("sub_pc", ex_pc_o, 32'h104);
    chk("no_bubble", lu_bubble_cnt_o, 0);

    // Load-use: one bubble, then the dependent add enters EX.
    step(instr(32'h108, 5'd5, 5'd1, 5'd0, 1, 0, C_LOAD), rdy);
    s = instr(32'h10c, 5'd6, 5'd5, 5'd7, 1, 1, C_ALU);
    step(s, rdy);
    #1 chk("lu_ready", id_ready_o, 0);
    after_edge();
    chk("lu_bubble_valid", ex_valid_o, 0);
    chk("lu_bubble_ctrl", ex_ctrl_o, 0);
    chk("lu_bubble_cnt", lu_bubble_cnt_o, 1);
    s.d1 = $urandom;
    step(s, rdy);
    after_edge();
    chk("lu_add_pc", ex_pc_o, 32'h10c);

    // Load to x0 never stalls.
    step(instr(32'h110, 5'd0, 5'd1, 5'd0, 1, 0, C_LOAD), rdy);
    step(instr(32'h114, 5'd8, 5'd0, 5'd0, 1, 1, C_ALU), rdy);
    #1 chk("x0_ready", id_ready_o, 1);
    // Matching rs2 index that is not read does not stall.
    step(instr(32'h118, 5'd5, 5'd1, 5'd0, 1, 0, C_LOAD), rdy);
    step(instr(32'h11c, 5'd9, 5'd1, 5'd5, 1, 0, C_ALU), rdy);
    #1 chk("rs2_unused_ready", id_ready_o, 1);
    after_edge();
    chk("rs2_unused_bub", lu_bubble_cnt_o, 1);

    // Back-pressure for three cycles.
    s = instr(32'h120, 5'd10, 5'd1, 5'd2, 1, 1, C_ALU);
    s.ex_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step(s, rdy);
      #1 chk("bp_ready", id_ready_o, 0);
    end
    after_edge();
    chk("bp_frozen_pc", ex_pc_o, 32'h11c);
    chk("bp_stall_cnt", ex_stall_cnt_o, 3);
    s.ex_ready = 1;
    step(s, rdy);
    after_edge();
    chk("bp_resume_pc", ex_pc_o, 32'h120);

    // Flush beats both back-pressure and a pending hazard.
    step(instr(32'h124, 5'd5, 5'd1, 5'd0, 1, 0, C_LOAD), rdy);
    s = instr(32'h128, 5'd11, 5'd5, 5'd5, 1, 1, C_ALU);
    s.ex_ready = 0; s.flush = 1;
    step(s, rdy);
    #1 chk("flush_ready", id_ready_o, 1);
    after_edge();
    chk("flush_valid", ex_valid_o, 0);
    chk("flush_ctrl", ex_ctrl_o, 0);
    chk("flush_counters", {lu_bubble_cnt_o, ex_stall_cnt_o}, {16'd1, 16'd3});

    // Asynchronous reset with a valid entry held.
    step(instr(32'h12c, 5'd12, 5'd1, 5'd2, 1, 1, C_ALU), rdy);
    step(rs, rdy);
    #1 chk("async_rst_valid", ex_valid_o, 0);
    chk("async_rst_pc", ex_pc_o, 0);
    chk("async_rst_cnt", {lu_bubble_cnt_o, ex_stall_cnt_o}, 0);
    chk("async_rst_ready", id_ready_o, 0);
    step(rs, rdy);
    step(instr(32'h200, 5'd13, 5'd1, 5'd2, 1, 1, C_ALU), rdy);
    after_edge();
    chk("post_rst_pc", ex_pc_o, 32'h200);

    // Randomized traffic; an unconsumed instruction is re-presented with fresh read data.
    pending = 0;
    cur = instr(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      if (!pending) begin
        cur = instr($urandom, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 8'($urandom));
        cur.id_valid = ($urandom_range(0, 9) < 8);
      end
      cur.d1 = $urandom; cur.d2 = $urandom;
      cur.ex_ready = ($urandom_range(0, 9) < 8);
      cur.flush    = ($urandom_range(0, 19) == 0);
      step(cur, rdy);
      pending = cur.id_valid && !rdy;
    end

    // Stall counter saturation.
    s = instr(32'h300, 5'd14, 5'd1, 5'd2, 1, 1, C_ALU);
    step(s, rdy);
    s.ex_ready = 0;
    for (int i = 0; i < 65540; i++) step(s, rdy);
    after_edge();
    chk("stall_saturated", ex_stall_cnt_o, 16'hFFFF);

    repeat (3) @(posedge clk);
    #3;
    chk("queues_drained", exp_q.size() + rdy_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
